// File: rtl/mips32_fwd_core.sv
// mips32_fwd_core: 5-stage MIPS32-subset pipeline with EX/MEM and MEM/WB forwarding or interlock-only hazard handling
module mips32_fwd_core #(
  parameter int   XLEN   = 32,
  parameter int   AW     = 10,
  parameter logic FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            busy,
  output logic            halted,
  output logic [31:0]     retired
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, HALT = 2'd3;
  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03,
                         OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09,
                         OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C,
                         OP_BNEQZ = 6'h0D, OP_BEQZ = 6'h0E, OP_HLT = 6'h3F;
  logic [1:0]      state, state_n;
  logic [AW-1:0]   pc, target;
  logic [XLEN-1:0] mem [2**AW];
  logic [XLEN-1:0] rf [32];
  logic            ifid_v;
  logic [31:0]     ifid_ir, fetch_ir;
  logic [AW-1:0]   ifid_pc, idex_pc;
  logic            idex_v, idex_wen;
  logic [5:0]      idex_op;
  logic [4:0]      idex_rs, idex_rt, idex_dest;
  logic [XLEN-1:0] idex_a, idex_b, idex_imm;
  logic            exmem_v, exmem_wen;
  logic [5:0]      exmem_op;
  logic [4:0]      exmem_dest;
  logic [XLEN-1:0] exmem_res, exmem_sd, mem_rd;
  logic            memwb_v, memwb_wen, memwb_hlt, wb_we;
  logic [4:0]      memwb_dest;
  logic [XLEN-1:0] memwb_res;
  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_dest;
  logic            id_rr, id_ri, id_lw, id_sw, id_br, id_hlt, id_use_rs, id_use_rt, id_wen;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  logic            hit_ex, hit_mem, stall, take, adv;
  logic            m_rs, w_rs, m_rt, w_rt;
  logic [XLEN-1:0] fa, fb, ex_res;

  assign busy      = state == RUN || state == DRAIN;
  assign halted    = state == HALT;
  assign dbg_rdata = dbg_raddr == '0 ? '0 : rf[dbg_raddr];
  assign fetch_ir  = 32'(mem[pc]);
  assign mem_rd    = mem[AW'(exmem_res)];
  assign wb_we     = memwb_v && memwb_wen;

  assign id_op     = ifid_ir[31:26];
  assign id_rs     = ifid_ir[25:21];
  assign id_rt     = ifid_ir[20:16];
  assign id_imm    = XLEN'($signed(ifid_ir[15:0]));
  assign id_rr     = id_op <= OP_MUL;
  assign id_ri     = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
  assign id_lw     = id_op == OP_LW;
  assign id_sw     = id_op == OP_SW;
  assign id_br     = id_op == OP_BEQZ || id_op == OP_BNEQZ;
  assign id_hlt    = id_op == OP_HLT;
  assign id_use_rs = id_rr || id_ri || id_lw || id_sw || id_br;
  assign id_use_rt = id_rr || id_sw;
  assign id_dest   = id_rr ? ifid_ir[15:11] : id_rt;
  assign id_wen    = (id_rr || id_ri || id_lw) && id_dest != '0;
  assign id_a      = id_rs == '0 ? '0 : (wb_we && memwb_dest == id_rs) ? memwb_res : rf[id_rs];
  assign id_b      = id_rt == '0 ? '0 : (wb_we && memwb_dest == id_rt) ? memwb_res : rf[id_rt];

  assign hit_ex  = idex_v && idex_wen &&
                   ((id_use_rs && idex_dest == id_rs) || (id_use_rt && idex_dest == id_rt));
  assign hit_mem = exmem_v && exmem_wen &&
                   ((id_use_rs && exmem_dest == id_rs) || (id_use_rt && exmem_dest == id_rt));
  assign stall   = ifid_v && (FWD_EN ? (hit_ex && idex_op == OP_LW) : (hit_ex || hit_mem));

  assign m_rs = FWD_EN && exmem_v && exmem_wen && exmem_op != OP_LW && exmem_dest == idex_rs;
  assign m_rt = FWD_EN && exmem_v && exmem_wen && exmem_op != OP_LW && exmem_dest == idex_rt;
  assign w_rs = FWD_EN && wb_we && memwb_dest == idex_rs;
  assign w_rt = FWD_EN && wb_we && memwb_dest == idex_rt;
  assign fa   = m_rs ? exmem_res : w_rs ? memwb_res : idex_a;
  assign fb   = m_rt ? exmem_res : w_rt ? memwb_res : idex_b;

  always_comb begin
    ex_res = '0;
    case (idex_op)
      OP_ADD:                 ex_res = fa + fb;
      OP_SUB:                 ex_res = fa - fb;
      OP_AND:                 ex_res = fa & fb;
      OP_OR:                  ex_res = fa | fb;
      OP_SLT:                 ex_res = XLEN'($signed(fa) < $signed(fb));
      OP_MUL:                 ex_res = fa * fb;
      OP_LW, OP_SW, OP_ADDI:  ex_res = fa + idex_imm;
      OP_SUBI:                ex_res = fa - idex_imm;
      OP_SLTI:                ex_res = XLEN'($signed(fa) < $signed(idex_imm));
      default:                ex_res = '0;
    endcase
  end

  assign take   = idex_v && ((idex_op == OP_BEQZ && fa == '0) || (idex_op == OP_BNEQZ && fa != '0));
  assign target = idex_pc + AW'(1) + AW'(idex_imm);
  assign adv    = state == RUN && !stall && !take;

  assign state_n = state == IDLE  ? (run ? RUN : IDLE) :
                   state == RUN   ? ((adv && ifid_v && id_hlt) ? DRAIN : RUN) :
                   state == DRAIN ? ((memwb_v && memwb_hlt) ? HALT : take ? RUN : DRAIN) :
                   HALT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ifid_v  <= 1'b0;
      idex_v  <= 1'b0;
      exmem_v <= 1'b0;
      memwb_v <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      if (busy) begin
        pc <= take ? target : adv ? pc + AW'(1) : pc;
        if (take) ifid_v <= 1'b0;
        else if (adv) begin
          ifid_v  <= 1'b1;
          ifid_ir <= fetch_ir;
          ifid_pc <= pc;
        end
        idex_v     <= adv && ifid_v;
        idex_op    <= id_op;
        idex_rs    <= id_rs;
        idex_rt    <= id_rt;
        idex_dest  <= id_dest;
        idex_wen   <= id_wen;
        idex_a     <= id_a;
        idex_b     <= id_b;
        idex_imm   <= id_imm;
        idex_pc    <= ifid_pc;
        exmem_v    <= idex_v;
        exmem_op   <= idex_op;
        exmem_dest <= idex_dest;
        exmem_wen  <= idex_wen;
        exmem_res  <= ex_res;
        exmem_sd   <= fb;
        memwb_v    <= exmem_v;
        memwb_hlt  <= exmem_op == OP_HLT;
        memwb_dest <= exmem_dest;
        memwb_wen  <= exmem_wen;
        memwb_res  <= exmem_op == OP_LW ? mem_rd : exmem_res;
        if (wb_we) rf[memwb_dest] <= memwb_res;
        if (memwb_v) retired <= retired + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && ld_we) mem[ld_addr] <= ld_data;
    else if (!rst && busy && exmem_v && exmem_op == OP_SW) mem[AW'(exmem_res)] <= exmem_sd;
  end
endmodule

// File: tb/tb_mips32_fwd_core.sv
// tb_mips32_fwd_core: table-driven program checks on forwarding and interlock instances
module tb_mips32_fwd_core;
  localparam logic [5:0] ADD = 6'h00, MUL = 6'h05, LW = 6'h08, SW = 6'h09, ADDI = 6'h0A,
                         SUBI = 6'h0B, BNEQZ = 6'h0D, BEQZ = 6'h0E, HLT = 6'h3F;
  typedef struct {
    int p; int cyc_f; int cyc_i; int ret;
    int ra; logic [31:0] va; int rb; logic [31:0] vb; int rc; logic [31:0] vc;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, run = 1'b0, ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata1, dbg_rdata0, retired1, retired0;
  logic        busy1, busy0, halted1, halted0;
  logic [31:0] prog [5][8];
  vec_t        vecs [5];
  int          n_cmp = 0, n_bad = 0;
  int          c1, c0;

  always #5 clk = ~clk;

  mips32_fwd_core #(.XLEN(32), .AW(10), .FWD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .run(run), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata1), .busy(busy1), .halted(halted1), .retired(retired1));
  mips32_fwd_core #(.XLEN(32), .AW(10), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata0), .busy(busy0), .halted(halted0), .retired(retired0));

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic rchk(input string nm, input int idx, input logic [31:0] exp);
    @(negedge clk);
    dbg_raddr = 5'(idx);
    #1;
    chk({nm, " fwd"}, dbg_rdata1, exp);
    chk({nm, " ilk"}, dbg_rdata0, exp);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input int p);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ld_we = 1'b1;
      ld_addr = 10'(i);
      ld_data = prog[p][i];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic run_prog(output int h1, output int h0);
    h1 = -1;
    h0 = -1;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    for (int n = 1; n <= 200 && (h1 < 0 || h0 < 0); n++) begin
      @(posedge clk);
      #1;
      if (h1 < 0 && halted1) h1 = n;
      if (h0 < 0 && halted0) h0 = n;
    end
  endtask

  initial begin
    for (int p = 0; p < 5; p++) for (int i = 0; i < 8; i++) prog[p][i] = '0;
    prog[0][0] = ri(ADDI, 0, 1, 16'd10);
    prog[0][1] = ri(ADDI, 0, 2, 16'd20);
    prog[0][2] = rr(ADD, 1, 2, 3);
    prog[0][3] = {HLT, 26'd0};
    prog[1][0] = ri(ADDI, 0, 1, 16'd7);
    prog[1][1] = ri(SW, 0, 1, 16'd5);
    prog[1][2] = ri(LW, 0, 2, 16'd5);
    prog[1][3] = rr(ADD, 2, 2, 3);
    prog[1][4] = {HLT, 26'd0};
    prog[2] = prog[1];
    prog[2][3] = rr(ADD, 1, 1, 3);
    prog[3][0] = ri(ADDI, 0, 1, 16'd5);
    prog[3][1] = ri(ADDI, 0, 2, 16'd1);
    prog[3][2] = rr(MUL, 2, 1, 2);
    prog[3][3] = ri(SUBI, 1, 1, 16'd1);
    prog[3][4] = ri(BNEQZ, 1, 0, 16'hFFFD);
    prog[3][5] = {HLT, 26'd0};
    prog[4][0] = ri(BEQZ, 0, 0, 16'd2);
    prog[4][1] = {HLT, 26'd0};
    prog[4][2] = ri(ADDI, 0, 9, 16'd1);
    prog[4][3] = ri(ADDI, 0, 4, 16'd3);
    prog[4][4] = ri(ADDI, 0, 0, 16'd5);
    prog[4][5] = rr(ADD, 0, 0, 5);
    prog[4][6] = {HLT, 26'd0};
    vecs[0] = '{0, 8, 10, 4, 3, 30, 1, 10, 2, 20};
    vecs[1] = '{1, 10, 13, 5, 3, 14, 2, 7, 1, 7};
    vecs[2] = '{2, 9, 11, 5, 3, 14, 2, 7, 1, 7};
    vecs[3] = '{3, 30, 42, 18, 2, 120, 1, 0, 3, 0};
    vecs[4] = '{4, 11, 11, 5, 4, 3, 9, 0, 5, 0};

    do_rst();
    #1;
    chk("rst busy", {31'd0, busy1}, 32'd0);
    chk("rst halted", {31'd0, halted1}, 32'd0);
    chk("rst retired", retired1, 32'd0);
    chk("rst busy ilk", {31'd0, busy0}, 32'd0);
    chk("rst retired ilk", retired0, 32'd0);
    for (int r = 0; r < 32; r++) rchk($sformatf("rst r%0d", r), r, 32'd0);

    foreach (vecs[i]) begin
      do_rst();
      load(vecs[i].p);
      run_prog(c1, c0);
      chk($sformatf("v%0d halt cycles fwd", i), c1, vecs[i].cyc_f);
      chk($sformatf("v%0d halt cycles ilk", i), c0, vecs[i].cyc_i);
      chk($sformatf("v%0d retired fwd", i), retired1, vecs[i].ret);
      chk($sformatf("v%0d retired ilk", i), retired0, vecs[i].ret);
      chk($sformatf("v%0d busy after halt", i), {31'd0, busy1}, 32'd0);
      rchk($sformatf("v%0d r%0d", i, vecs[i].ra), vecs[i].ra, vecs[i].va);
      rchk($sformatf("v%0d r%0d", i, vecs[i].rb), vecs[i].rb, vecs[i].vb);
      rchk($sformatf("v%0d r%0d", i, vecs[i].rc), vecs[i].rc, vecs[i].vc);
    end
    rchk("r0 after write", 0, 32'd0);

    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    chk("run in halted: halted", {31'd0, halted1}, 32'd1);
    chk("run in halted: busy", {31'd0, busy1}, 32'd0);
    chk("run in halted: retired", retired1, 32'd5);
    chk("run in halted: retired ilk", retired0, 32'd5);

    do_rst();
    load(3);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    ld_we = 1'b1;
    ld_addr = 10'd0;
    ld_data = ri(ADDI, 0, 1, 16'd3);
    @(negedge clk);
    ld_we = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid-loop busy", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", {31'd0, busy1}, 32'd0);
    chk("mid rst busy ilk", {31'd0, busy0}, 32'd0);
    chk("mid rst retired", retired1, 32'd0);
    rchk("mid rst r1", 1, 32'd0);
    rchk("mid rst r2", 2, 32'd0);
    run_prog(c1, c0);
    chk("rerun halt cycles fwd", c1, 32'd30);
    chk("rerun halt cycles ilk", c0, 32'd42);
    chk("rerun retired", retired1, 32'd18);
    rchk("rerun r2", 2, 32'd120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
